cnn_frame_sequencer: RTL

//  Frame-level controller for the MNIST CNN datapath.
//  On a start request it clears the pipeline (conv1 -> maxpool -> conv2 -> maxpool -> fc -> comparator).
//  It then streams one 28x28 8-bit image from a synchronous pixel RAM into conv1 data_in.
//  It waits for the comparator result, latches the decision and reports done or timeout.
//  It replaces free-running pixel feeding with a start/busy/done handshake for back-to-back frames.

---
 rtl/cnn_frame_sequencer_if.sv | 41 ++++
 rtl/cnn_frame_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/cnn_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : cnn_frame_sequencer_if
// Purpose : Handshake, pixel-RAM and result bus between the frame sequencer
//           and its environment (RAM, conv1 input, comparator, host).
// Revision: 1.0 - initial release
// ============================================================================
interface cnn_frame_sequencer_if #(
  parameter int ADDR_BITS = 10
);
  logic                 start;
  logic                 abort;
  logic                 busy;
  logic                 mem_rd_en;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [7:0]           mem_rdata;
  logic [7:0]           pix_out;
  logic                 pix_valid;
  logic                 pipe_rst_n;
  logic                 res_valid;
  logic [3:0]           res_decision;
  logic [3:0]           decision;
  logic                 done;
  logic                 timeout_err;
  logic [15:0]          frame_cnt;

  // Environment side: host, pixel RAM and comparator
  modport master (
    output start, abort, mem_rdata, res_valid, res_decision,
    input  busy, mem_rd_en, mem_addr, pix_out, pix_valid, pipe_rst_n,
           decision, done, timeout_err, frame_cnt
  );

  // Sequencer side
  modport slave (
    input  start, abort, mem_rdata, res_valid, res_decision,
    output busy, mem_rd_en, mem_addr, pix_out, pix_valid, pipe_rst_n,
           decision, done, timeout_err, frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/cnn_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : cnn_frame_sequencer
// Purpose : Frame controller for the MNIST CNN datapath. Flushes the pipeline,
//           streams one image from the pixel RAM into conv1, then waits for
//           the comparator decision (or a timeout) and reports completion.
// Revision: 1.0 - initial release
// ============================================================================
module cnn_frame_sequencer #(
  parameter int IMG_PIXELS     = 784,
  parameter int ADDR_BITS      = 10,
  parameter int FLUSH_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_BITS        = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cnn_frame_sequencer_if.slave  sq_if
);

  localparam int FL_BITS = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FL_BITS-1:0]   C_FLUSH_LAST = FL_BITS'(FLUSH_CYCLES - 1);
  localparam logic [ADDR_BITS-1:0] C_ADDR_LAST  = ADDR_BITS'(IMG_PIXELS - 1);
  localparam logic [TO_BITS-1:0]   C_TO_LAST    = TO_BITS'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FLUSH    = 3'd1,
    S_STREAM   = 3'd2,
    S_WAIT_RES = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [FL_BITS-1:0]   flush_cnt_q, flush_cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [TO_BITS-1:0]   to_cnt_q, to_cnt_d;
  logic                 pix_valid_q, pix_valid_d;
  logic                 pipe_rst_n_q, pipe_rst_n_d;
  logic [3:0]           decision_q, decision_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic                 abort_hit;

  // Next-state, counter and result logic; abort overrides everything else
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = '0;
    addr_d        = '0;
    to_cnt_d      = '0;
    pix_valid_d   = 1'b0;
    decision_d    = decision_q;
    timeout_err_d = timeout_err_q;
    frame_cnt_d   = frame_cnt_q;
    abort_hit     = sq_if.abort && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (sq_if.start && !sq_if.abort) begin
          state_d       = S_FLUSH;
          timeout_err_d = 1'b0;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == C_FLUSH_LAST) begin
          state_d = S_STREAM;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      S_STREAM: begin
        // The read issued this cycle returns data next cycle, which is
        // exactly when pix_valid is asserted for it.
        pix_valid_d = 1'b1;
        if (addr_q == C_ADDR_LAST) begin
          addr_d  = addr_q;
          state_d = S_WAIT_RES;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_WAIT_RES: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (sq_if.res_valid) begin
          decision_d = sq_if.res_decision;
          state_d    = S_DONE;
        end else if (to_cnt_q == C_TO_LAST) begin
          decision_d    = 4'hF;
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_hit) begin
      state_d       = S_IDLE;
      addr_d        = '0;
      to_cnt_d      = '0;
      pix_valid_d   = 1'b0;
      decision_d    = decision_q;
      timeout_err_d = timeout_err_q;
      frame_cnt_d   = frame_cnt_q;
    end

    // Datapath clear tracks the FLUSH state, plus one cycle after an abort
    pipe_rst_n_d = !((state_d == S_FLUSH) || abort_hit);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      flush_cnt_q   <= '0;
      addr_q        <= '0;
      to_cnt_q      <= '0;
      pix_valid_q   <= 1'b0;
      pipe_rst_n_q  <= 1'b0;
      decision_q    <= 4'h0;
      timeout_err_q <= 1'b0;
      frame_cnt_q   <= 16'h0000;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      addr_q        <= addr_d;
      to_cnt_q      <= to_cnt_d;
      pix_valid_q   <= pix_valid_d;
      pipe_rst_n_q  <= pipe_rst_n_d;
      decision_q    <= decision_d;
      timeout_err_q <= timeout_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign sq_if.busy        = (state_q != S_IDLE);
  assign sq_if.mem_rd_en   = (state_q == S_STREAM);
  assign sq_if.mem_addr    = addr_q;
  assign sq_if.pix_valid   = pix_valid_q;
  // RAM data is valid in the cycle after the read, so it passes straight out
  assign sq_if.pix_out     = pix_valid_q ? sq_if.mem_rdata : 8'h00;
  assign sq_if.pipe_rst_n  = pipe_rst_n_q;
  assign sq_if.decision    = decision_q;
  assign sq_if.done        = (state_q == S_DONE);
  assign sq_if.timeout_err = timeout_err_q;
  assign sq_if.frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire
